// File: rtl/counter_3_bit_ctrl.sv
// counter_3_bit_ctrl: start/stop run controller around a WIDTH-bit up/down counter with terminal count,
// auto-reload, done pulse and saturating run tally. Define COUNTER_CTRL_PAUSE_EN to enable pause/HOLD.
module counter_3_bit_ctrl #(
    parameter int WIDTH  = 3,
    parameter int RUNS_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic [WIDTH-1:0]  i_term,
    input  logic              i_down,
    input  logic              i_reload,
    output logic [WIDTH-1:0]  o_count,
    output logic              o_busy,
    output logic              o_done,
    output logic [RUNS_W-1:0] o_runs
);
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [RUNS_W-1:0] RUNS_ONE = RUNS_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_count, w_count_nxt;
    logic [WIDTH-1:0]    r_term, w_term_nxt;
    logic                r_down, w_down_nxt;
    logic                r_reload, w_reload_nxt;
    logic                r_done, w_done_nxt;
    logic                r_busy, w_busy_nxt;
    logic [RUNS_W-1:0]   r_runs, w_runs_nxt;
    logic                w_at_end;
    logic [WIDTH-1:0]    w_step;
    logic [WIDTH-1:0]    w_restart;
    logic [RUNS_W-1:0]   w_runs_inc;

`ifndef COUNTER_CTRL_PAUSE_EN
    logic w_unused_pause;
    assign w_unused_pause = i_pause;
`endif

    // end value is term when counting up, zero when counting down
    assign w_at_end   = r_count == (r_down ? '0 : r_term);
    assign w_step     = r_down ? r_count - CNT_ONE : r_count + CNT_ONE;
    assign w_restart  = r_down ? r_term : '0;
    assign w_runs_inc = &r_runs ? r_runs : r_runs + RUNS_ONE;
    assign w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == HOLD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_term   <= '0;
            r_down   <= 1'b0;
            r_reload <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_runs   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_term   <= w_term_nxt;
            r_down   <= w_down_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_runs   <= w_runs_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_term_nxt   = r_term;
        w_down_nxt   = r_down;
        w_reload_nxt = r_reload;
        w_runs_nxt   = r_runs;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_state_nxt  = RUN;
                    w_term_nxt   = i_term;
                    w_down_nxt   = i_down;
                    w_reload_nxt = i_reload;
                    w_count_nxt  = i_down ? i_term : '0;
                    w_runs_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
`ifdef COUNTER_CTRL_PAUSE_EN
            RUN, HOLD: begin
`else
            RUN: begin
`endif
                if (i_stop) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else if (w_at_end) begin
                    w_done_nxt  = 1'b1;
                    w_runs_nxt  = w_runs_inc;
                    w_state_nxt = r_reload ? RUN : DONE;
                    w_count_nxt = r_reload ? w_restart : r_count;
`ifdef COUNTER_CTRL_PAUSE_EN
                end else if (i_pause) begin
                    w_state_nxt = HOLD;
`endif
                end else begin
                    w_state_nxt = RUN;
                    w_count_nxt = w_step;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_count = r_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_runs  = r_runs;
endmodule
